// File: rtl/seg7_scan_ctrl_if.sv
// Bus bundle for the multiplexed 7-segment scan controller: display data,
// live mode selects and the scanned segment/anode outputs.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   hexs;
    logic [8*DIGITS-1:0]   raw;
    logic [DIGITS-1:0]     point;
    logic [DIGITS-1:0]     les;
    logic                  mode;
    logic                  blank_lz;
    logic [7:0]            segment;
    logic [DIGITS-1:0]     an;
    logic                  pending;

    modport master (
        output load, hexs, raw, point, les, mode, blank_lz,
        input  segment, an, pending
    );

    modport slave (
        input  load, hexs, raw, point, les, mode, blank_lz,
        output segment, an, pending
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment display driver with shadow/active data sets,
// hex decode, leading-zero blanking and per-digit blinking.
module seg7_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] hex;
        logic [8*DIGITS-1:0] raw;
        logic [DIGITS-1:0]   point;
        logic [DIGITS-1:0]   les;
    } disp_set_t;

    // Active-low g..a pattern for one hex nibble (dp handled separately).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              blink_q, blink_d;
    logic              pend_q, pend_d;
    disp_set_t         shadow_q, shadow_d;
    disp_set_t         active_q, active_d;
    disp_set_t         in_set;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic              slot_tick;
    logic              frame_tick;
    int                sel;
    logic [3:0]        nib;
    logic              lz_blank;
    logic              dp_n;

    always_comb begin
        in_set.hex   = bus.hexs;
        in_set.raw   = bus.raw;
        in_set.point = bus.point;
        in_set.les   = bus.les;
    end

    // Scan timing: prescaler -> digit index -> frame counter -> blink phase.
    always_comb begin
        slot_tick  = (presc_q == PRESC_LAST);
        frame_tick = slot_tick && (idx_q == IDX_LAST);
        presc_d    = slot_tick ? '0 : presc_q + PW'(1);
        idx_d      = idx_q;
        if (slot_tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        frame_d = frame_q;
        blink_d = blink_q;
        if (frame_tick) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    // A load landing on the frame tick bypasses the shadow wait entirely.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        if (bus.load) begin
            shadow_d = in_set;
        end
        if (frame_tick) begin
            if (bus.load) begin
                active_d = in_set;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
            end
        end else if (bus.load) begin
            pend_d = 1'b1;
        end
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        sel      = int'(idx_q);
        nib      = active_q.hex[4*sel +: 4];
        dp_n     = ~active_q.point[sel];
        lz_blank = (sel != 0);
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= sel && active_q.hex[4*j +: 4] != 4'h0) begin
                lz_blank = 1'b0;
            end
        end
        if (!bus.mode) begin
            seg_d = active_q.raw[8*sel +: 8];
        end else if (bus.blank_lz && lz_blank) begin
            seg_d = {dp_n, 7'h7F};
        end else begin
            seg_d = {dp_n, hex_to_seg(nib)};
        end
        if (blink_q && active_q.les[sel]) begin
            seg_d = 8'hFF;
        end
        an_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            blink_q  <= 1'b0;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            seg_q    <= 8'hFF;
            an_q     <= '1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            blink_q  <= blink_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign bus.segment = seg_q;
    assign bus.an      = an_q;
    assign bus.pending = pend_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a cycle-count based reference model.
module tb_seg7_scan_ctrl;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME_CYC = SD * D;

    localparam logic [7:0] HEX_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk;
    logic rst_n;

    seg7_scan_ctrl_if #(.DIGITS(D)) bus ();

    seg7_scan_ctrl #(
        .DIGITS      (D),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 0;

    // Reference model state: edges since reset plus shadow/active sets.
    int          k = 0;
    logic [15:0] sh_hx = '0, ac_hx = '0;
    logic [31:0] sh_rw = '0, ac_rw = '0;
    logic [3:0]  sh_pt = '0, ac_pt = '0, sh_ls = '0, ac_ls = '0;
    logic        m_pend = 1'b0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [3:0]  exp_an  = 4'hF;
    logic        exp_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input int d, input logic [15:0] hx,
                                           input logic [31:0] rw, input logic [3:0] pt,
                                           input logic [3:0] ls, input logic md,
                                           input logic blz, input int ph);
        logic [7:0] s;
        if (ph == 1 && ls[d]) return 8'hFF;
        if (!md) return rw[8*d +: 8];
        if (blz && d > 0 && (hx >> (4*d)) == 16'h0) s = 8'hFF;
        else s = HEX_TBL[int'((hx >> (4*d)) & 16'hF)];
        if (pt[d]) s = s & 8'h7F;
        return s;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0;
                sh_hx = '0; ac_hx = '0; sh_rw = '0; ac_rw = '0;
                sh_pt = '0; ac_pt = '0; sh_ls = '0; ac_ls = '0;
                m_pend = 1'b0;
                exp_seg = 8'hFF; exp_an = 4'hF; exp_pend = 1'b0;
            end else begin
                int d, f, ph;
                bit ft;
                k++;
                d  = ((k - 1) / SD) % D;
                f  = (k - 1) / FRAME_CYC;
                ph = (f / BF) % 2;
                exp_an  = 4'hF & ~(4'b0001 << d);
                exp_seg = ref_seg(d, ac_hx, ac_rw, ac_pt, ac_ls, bus.mode, bus.blank_lz, ph);
                ft = (k % FRAME_CYC) == 0;
                if (bus.load) begin
                    sh_hx = bus.hexs; sh_rw = bus.raw; sh_pt = bus.point; sh_ls = bus.les;
                end
                if (ft && bus.load) begin
                    ac_hx = sh_hx; ac_rw = sh_rw; ac_pt = sh_pt; ac_ls = sh_ls;
                    m_pend = 1'b0;
                end else if (ft && m_pend) begin
                    ac_hx = sh_hx; ac_rw = sh_rw; ac_pt = sh_pt; ac_ls = sh_ls;
                    m_pend = 1'b0;
                end else if (bus.load) begin
                    m_pend = 1'b1;
                end
                exp_pend = m_pend;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("an", 32'(bus.an), 32'(exp_an));
                check("seg", 32'(bus.segment), 32'(exp_seg));
                check("pend", 32'(bus.pending), 32'(exp_pend));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] hx, input logic [31:0] rw,
                           input logic [3:0] pt, input logic [3:0] ls);
        bus.load = 1'b1; bus.hexs = hx; bus.raw = rw; bus.point = pt; bus.les = ls;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Align so the next rising edge is at position p within the frame.
    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * FRAME_CYC && ((k + 1) % FRAME_CYC) != p; i++) cyc(1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load = 1'b0; bus.hexs = '0; bus.raw = '0; bus.point = '0; bus.les = '0;
        bus.mode = 1'b1; bus.blank_lz = 1'b0;
        cyc(3);
        chk_en = 1;
        check("rst_seg", 32'(bus.segment), 32'hFF);
        check("rst_an", 32'(bus.an), 32'hF);
        rst_n = 1'b1;

        cyc(17);
        check("an_wrap", 32'(bus.an), 32'b1110);
        check("pend_idle", 32'(bus.pending), 32'h0);

        cyc(5);
        do_load(16'h1F80, 32'h0, 4'b0001, 4'b0000);
        check("pend_set", 32'(bus.pending), 32'h1);
        cyc(40);

        do_load(16'h0005, 32'h0, 4'b0000, 4'b0000);
        bus.blank_lz = 1'b1;
        cyc(40);
        bus.blank_lz = 1'b0;
        cyc(20);

        do_load(16'h4321, 32'h0, 4'b0000, 4'b0010);
        cyc(80);

        wait_phase(2);
        do_load(16'h1111, 32'h0, 4'b0000, 4'b0000);
        cyc(2);
        do_load(16'h2222, 32'h0, 4'b0000, 4'b0000);
        cyc(30);
        wait_phase(0);
        do_load(16'h5678, 32'h0, 4'b0100, 4'b0000);
        check("pend_tick", 32'(bus.pending), 32'h0);
        cyc(20);

        bus.mode = 1'b0; bus.blank_lz = 1'b1;
        do_load(16'h0000, 32'h00FF7F80, 4'b1111, 4'b0000);
        cyc(40);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                bus.mode = 1'($urandom);
                bus.blank_lz = 1'($urandom);
            end
            if ($urandom_range(0, 7) == 0 ||
                (((k + 1) % FRAME_CYC) == 0 && $urandom_range(0, 3) == 0)) begin
                do_load(16'($urandom >> $urandom_range(0, 31)), $urandom,
                        4'($urandom), 4'($urandom));
            end else begin
                cyc(1);
            end
        end

        bus.mode = 1'b1; bus.blank_lz = 1'b0;
        wait_phase(3);
        do_load(16'hABCD, 32'h0, 4'b1010, 4'b0000);
        check("pend_pre_rst", 32'(bus.pending), 32'h1);
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_seg", 32'(bus.segment), 32'hFF);
        check("rst_mid_an", 32'(bus.an), 32'hF);
        check("rst_mid_pend", 32'(bus.pending), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("post_rst_an", 32'(bus.an), 32'b1110);
        check("post_rst_seg", 32'(bus.segment), 32'hC0);
        cyc(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
